mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Types shared by the cache/RAM side of the CPU: the word type and the RAM
// status encoding reported on ramstate.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int ERRCNT_W = 8;
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of icache, dcache and RAM signals between the arbiter (slave) and
// the surrounding caches/RAM (master).
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    // Handshake: a cache holds its request (iREN/dREN/dWEN) and operands until
    // it sees its wait low for one cycle; that cycle completes the transfer and
    // the load data is valid in it. Dropping the request earlier abandons it.
    logic                iREN;
    word_t               iaddr;
    logic                iwait;
    word_t               iload;

    logic                dREN;
    logic                dWEN;
    word_t               daddr;
    word_t               dstore;
    logic                dwait;
    word_t               dload;

    logic                ramREN;
    logic                ramWEN;
    word_t               ramaddr;
    word_t               ramstore;
    word_t               ramload;
    ramstate_t           ramstate;

    logic [ERRCNT_W-1:0] errcnt;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, errcnt
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, errcnt
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache. Dcache has fixed
// priority (write over read); each grant runs until ACCESS or request drop.
module mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } arb_state_t;

    arb_state_t          state_q, state_d;
    word_t               addr_q, addr_d;
    word_t               store_q, store_d;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

    logic in_grant;
    logic req_held;
    logic ram_access;
    logic ram_error;

    assign in_grant   = (state_q != IDLE);
    assign ram_access = (bus.ramstate == ACCESS);
    assign ram_error  = (bus.ramstate == ERROR);

    // Request of whoever currently owns the RAM.
    always_comb begin
        req_held = 1'b0;
        unique case (state_q)
            IGRANT:  req_held = bus.iREN;
            DREAD:   req_held = bus.dREN;
            DWRITE:  req_held = bus.dWEN;
            default: req_held = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ERROR, FREE and BUSY all hold the grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.dWEN) begin
                    state_d = DWRITE;
                end else if (bus.dREN) begin
                    state_d = DREAD;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end
            end
            default: begin
                if (!req_held || ram_access) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Address/data are captured only when leaving IDLE, so the RAM sees a
    // stable operand for the whole grant even if the cache changes its bus.
    always_comb begin
        addr_d   = addr_q;
        store_d  = store_q;
        errcnt_d = errcnt_q;
        if (state_q == IDLE) begin
            if (bus.dWEN) begin
                addr_d  = bus.daddr;
                store_d = bus.dstore;
            end else if (bus.dREN) begin
                addr_d = bus.daddr;
            end else if (bus.iREN) begin
                addr_d = bus.iaddr;
            end
        end
        if (in_grant && ram_error && (errcnt_q != ERRCNT_MAX)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            addr_q   <= '0;
            store_q  <= '0;
            errcnt_q <= '0;
        end else begin
            addr_q   <= addr_d;
            store_q  <= store_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Output logic; nRST gates everything so reset values appear immediately.
    always_comb begin
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
        bus.iwait  = 1'b1;
        bus.dwait  = 1'b1;
        if (nRST) begin
            unique case (state_q)
                IGRANT: begin
                    bus.ramREN = 1'b1;
                    bus.iwait  = !ram_access;
                end
                DREAD: begin
                    bus.ramREN = 1'b1;
                    bus.dwait  = !ram_access;
                end
                DWRITE: begin
                    bus.ramWEN = 1'b1;
                    bus.dwait  = !ram_access;
                end
                default: begin
                    bus.ramREN = 1'b0;
                    bus.ramWEN = 1'b0;
                end
            endcase
        end
    end

    assign bus.ramaddr  = nRST ? addr_q  : '0;
    assign bus.ramstore = nRST ? store_q : '0;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign bus.errcnt   = errcnt_q;
    assign dbg_state_o  = state_q;

    a_one_command: assert property (@(posedge CLK) !(bus.ramREN && bus.ramWEN));
    a_one_release: assert property (@(posedge CLK) !(!bus.iwait && !bus.dwait));

endmodule
